// File: rtl/clock_phase_gen.sv
// Multi-channel programmable clock divider with per-channel ratio, phase and enable.
// Ratio/phase updates go through a shadow register and take effect at a period boundary.
module clock_phase_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4,
  parameter int CH_W        = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_stb,
  output logic              busy
);
  localparam int               SEL_N   = 1 << CH_W;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  function automatic logic [CNT_W-1:0] sat_div(input logic [CNT_W-1:0] d);
    return (d < TWO) ? TWO : d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_phase(input logic [CNT_W-1:0] p,
                                                 input logic [CNT_W-1:0] d);
    return (p >= d) ? '0 : p;
  endfunction

  // Counter value one step before the phase, so the first enabled cycle lands on it.
  function automatic logic [CNT_W-1:0] preload(input logic [CNT_W-1:0] d,
                                               input logic [CNT_W-1:0] p);
    return (p == '0) ? (d - ONE) : (p - ONE);
  endfunction

  function automatic logic is_high(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] d);
    logic [CNT_W:0] hi;
    hi = ({1'b0, d} + (CNT_W+1)'(1)) >> 1;
    return {1'b0, c} < hi;
  endfunction

  logic [NUM_CH-1:0] pend_all;
  logic [SEL_N-1:0]  pend_ext;

  assign pend_ext  = SEL_N'(pend_all);
  assign cfg_ready = ~pend_ext[cfg_ch];
  assign busy      = |pend_all;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_p0, div_p0, phase_p0, sdiv_p0, sphase_p0;
    logic             pend_p0, clk_p0, stb_p0;
    logic [CNT_W-1:0] div_eff, phase_eff, cnt_nx, new_div;
    logic             take, wrap, apply, clk_nx;

    assign take      = cfg_valid && (cfg_ch == CH_W'(i)) && !pend_p0;
    assign wrap      = (cnt_p0 == (div_p0 - ONE));
    assign div_eff   = pend_p0 ? sdiv_p0 : div_p0;
    assign phase_eff = pend_p0 ? sphase_p0 : phase_p0;
    assign new_div   = sat_div(cfg_div);

    always_comb begin
      cnt_nx = cnt_p0;
      clk_nx = 1'b0;
      apply  = 1'b0;
      if (!ch_enable[i]) begin
        apply  = pend_p0;
        cnt_nx = preload(div_eff, phase_eff);
      end else if (sync) begin
        apply  = pend_p0;
        cnt_nx = phase_eff;
        clk_nx = is_high(phase_eff, div_eff);
      end else if (wrap) begin
        // A pending ratio lands exactly at the period boundary, so neither level is cut short.
        apply  = pend_p0;
        cnt_nx = '0;
        clk_nx = 1'b1;
      end else begin
        cnt_nx = cnt_p0 + ONE;
        clk_nx = is_high(cnt_nx, div_p0);
      end
    end

    // Stage p0: per-channel state register
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_p0    <= DIV_RST - ONE;
        div_p0    <= DIV_RST;
        phase_p0  <= '0;
        sdiv_p0   <= DIV_RST;
        sphase_p0 <= '0;
        pend_p0   <= 1'b0;
        clk_p0    <= 1'b0;
        stb_p0    <= 1'b0;
      end else begin
        cnt_p0  <= cnt_nx;
        clk_p0  <= clk_nx;
        stb_p0  <= ~clk_p0 & clk_nx;
        pend_p0 <= take | (pend_p0 & ~apply);
        if (apply) begin
          div_p0   <= sdiv_p0;
          phase_p0 <= sphase_p0;
        end
        if (take) begin
          sdiv_p0   <= new_div;
          sphase_p0 <= sat_phase(cfg_phase, new_div);
        end
      end
    end

    assign clk_out[i]  = clk_p0;
    assign rise_stb[i] = stb_p0;
    assign pend_all[i] = pend_p0;
  end

endmodule
